mips_mem_responder: RTL and testbench

- Memory-side responder for the processor's load/store bus: the processor initiates, this block answers.
- Latches a request, inserts a fixed number of wait states, then completes the write or returns read data with a one-cycle ready pulse.
- Sits between the fproc core and its data memory. The testbench can use it as a slow-memory model for wait-state coverage.

---
 rtl/mips_mem_pkg.sv | 24 ++
 rtl/mips_mem_responder_if.sv | 29 ++
 rtl/mem_word_array.sv | 44 ++++
 rtl/mips_mem_responder.sv | 115 +++++++++++
 tb/tb_mips_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the load/store memory responder
// Purpose: FSM state encoding, bus constants and the word-index width helper.
// Ports: none (package).
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BE_W   = 4;
    localparam int ADDR_W = 32;

    // Width of the word index; at least one bit so a single-word memory still
    // has a legal index slice.
    function automatic int idx_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// rtl/mips_mem_responder_if.sv - processor load/store bus between core and memory responder
// Purpose: groups the request and response signals of the load/store bus.
// Ports (signals): req, we, addr, wdata, be (processor -> memory);
//                  ready, rdata, err (memory -> processor).
// Modports: master = processor side, slave = memory side.
interface mips_mem_responder_if
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, err
    );
endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word-wide register array with byte-lane writes and registered read
// Purpose: DEPTH_WORDS x DATA_W storage. Writes are synchronous per byte lane;
//          the read word is captured into rdata on the commit edge.
// Ports: clock, reset (sync, active-low, clears rdata only), wr_en, rd_en,
//        clr (force rdata to 0), index, wdata, be, rdata.
module mem_word_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);
    // Contents are intentionally never reset.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // rdata holds between accesses; stores leave it untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[index];
        end
    end
endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - slow-memory responder for the processor load/store bus
// Purpose: accepts a request in IDLE, waits WAIT_CYCLES, then commits the store
//          or returns load data together with a one-cycle ready pulse.
// Ports: clock, reset (sync, active-low), bus (slave side: req/we/addr/wdata/be
//        in, ready/rdata/err out).
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mips_mem_responder_if.slave   bus
);
    localparam int IDX_W = idx_width(DEPTH_WORDS);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              err_q;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              fault;
    logic              commit;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the acceptance edge, so
    // the live bus fields are used while in IDLE and the latched copy after.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_be    = lat_be;
        if (state == IDLE) begin
            cur_we    = bus.we;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
            cur_be    = bus.be;
        end
    end

    // Range check uses the full word index so high addresses never alias low words.
    assign fault  = (cur_addr[1:0] != 2'b00) ||
                    ({2'b00, cur_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
    // Gating with reset keeps an access interrupted by reset from committing.
    assign commit = reset && (state_next == RESP) && (state != RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (commit) err_q <= fault;
            if (state == IDLE && bus.req) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
                lat_be    <= bus.be;
            end
        end
    end

    assign bus.ready = (state == RESP);
    assign bus.err   = (state == RESP) && err_q;

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .wr_en (commit && cur_we && !fault),
        .rd_en (commit && !cur_we && !fault),
        .clr   (commit && fault),
        .index (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (bus.rdata)
    );
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - self-checking bench for the memory responder (2 and 0 wait states)
module tb_mips_mem_responder;
    logic        clock = 1'b0;
    logic [1:0]  reset_v = 2'b00;
    logic [1:0]  req_v = 2'b00;
    logic        we_v = 1'b0;
    logic [31:0] addr_v = '0;
    logic [31:0] wdata_v = '0;
    logic [3:0]  be_v = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] model [2][64];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // instance 0: WAIT_CYCLES=2, instance 1: WAIT_CYCLES=0
    mips_mem_responder_if #(.DATA_W(32)) bus2 ();
    mips_mem_responder_if #(.DATA_W(32)) bus0 ();

    assign bus2.req = req_v[0];  assign bus0.req = req_v[1];
    assign bus2.we = we_v;       assign bus0.we = we_v;
    assign bus2.addr = addr_v;   assign bus0.addr = addr_v;
    assign bus2.wdata = wdata_v; assign bus0.wdata = wdata_v;
    assign bus2.be = be_v;       assign bus0.be = be_v;

    mips_mem_responder #(.DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clock(clock), .reset(reset_v[0]), .bus(bus2));
    mips_mem_responder #(.DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset_v[1]), .bus(bus0));

    function automatic logic get_ready(input int s);
        return (s == 0) ? bus2.ready : bus0.ready;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? bus2.err : bus0.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return (s == 0) ? bus2.rdata : bus0.rdata;
    endfunction
    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access with reference-model prediction of err/rdata/latency.
    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input string tag);
        int k;
        logic flt;
        flt = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        @(negedge clock);
        we_v = w; addr_v = a; wdata_v = d; be_v = b; req_v[s] = 1'b1;
        @(negedge clock);
        req_v[s] = 1'b0;
        // bus inputs must be ignored once accepted
        we_v = 1'($urandom); addr_v = $urandom; wdata_v = $urandom; be_v = 4'($urandom);
        k = 0;
        while (!get_ready(s) && k < 20) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(wait_of(s)));
        if (flt) begin
            check({tag, "_err"}, 32'(get_err(s)), 32'd1);
            check({tag, "_rd0"}, get_rdata(s), 32'd0);
        end else begin
            check({tag, "_err"}, 32'(get_err(s)), 32'd0);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[s][a[7:2]][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                check({tag, "_rd"}, get_rdata(s), model[s][a[7:2]]);
            end
        end
        @(negedge clock);
        check({tag, "_pulse"}, {30'd0, get_ready(s), get_err(s)}, 32'd0);
        if (!w && !flt) check({tag, "_hold"}, get_rdata(s), model[s][a[7:2]]);
    endtask

    // Reset asserted while the access sits in WAIT: no pulse, no write.
    task automatic reset_mid(input int s);
        int pulses;
        @(negedge clock);
        we_v = 1'b1; addr_v = 32'h20; wdata_v = 32'hCAFEF00D; be_v = 4'hF; req_v[s] = 1'b1;
        @(negedge clock);
        req_v[s] = 1'b0; reset_v[s] = 1'b0;
        @(negedge clock);
        reset_v[s] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (get_ready(s)) pulses++;
            @(negedge clock);
        end
        check("rstmid_pulses", 32'(pulses), 32'd0);
        access(s, 1'b0, 32'h20, 32'h0, 4'h0, "rstmid_ld");
    endtask

    // req held high: pulses spaced WAIT_CYCLES+2 apart, each with correct data.
    task automatic held_req(input int s, input logic [5:0] idx);
        int t[$];
        @(negedge clock);
        we_v = 1'b0; addr_v = {24'd0, idx, 2'b00}; req_v[s] = 1'b1;
        for (int i = 0; i < 60 && t.size() < 4; i++) begin
            @(negedge clock);
            if (get_ready(s)) begin
                t.push_back(cyc);
                check("held_rd", get_rdata(s), model[s][idx]);
            end
        end
        req_v[s] = 1'b0;
        check("held_cnt", 32'(t.size()), 32'd4);
        for (int i = 1; i < t.size(); i++)
            check("held_gap", 32'(t[i] - t[i-1]), 32'(wait_of(s) + 2));
        @(negedge clock);
        @(negedge clock);
        check("held_idle", 32'(get_ready(s)), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int s, r;
        // reset held with req asserted
        reset_v = 2'b00; req_v = 2'b11; addr_v = 32'h10; we_v = 1'b1; wdata_v = 32'h1234; be_v = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                check("rst_ready", 32'(get_ready(i)), 32'd0);
                check("rst_err", 32'(get_err(i)), 32'd0);
                check("rst_rdata", get_rdata(i), 32'd0);
            end
        end
        req_v = 2'b00; reset_v = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) check("post_rst_idle", 32'(get_ready(i)), 32'd0);
        end

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++)
                access(i, 1'b1, 32'(j * 4), $urandom, 4'hF, "init");

        for (int i = 0; i < 2; i++) begin
            access(i, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
            access(i, 1'b0, 32'h10, 32'h0, 4'h0, "ld10");
            check("ld10_val", get_rdata(i), 32'hDEADBEEF);
            access(i, 1'b1, 32'h10, 32'h11223344, 4'b0101, "stpart");
            access(i, 1'b0, 32'h10, 32'h0, 4'h0, "ldpart");
            check("part_val", get_rdata(i), 32'hDE22BE44);
            access(i, 1'b0, 32'h13, 32'h0, 4'h0, "ld_mis");
            access(i, 1'b1, 32'h100, 32'h55AA55AA, 4'hF, "st_oor");
            access(i, 1'b0, 32'h0, 32'h0, 4'h0, "ld_w0");
            access(i, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, "st_be0");
            access(i, 1'b0, 32'h10, 32'h0, 4'h0, "ld_be0");
            check("be0_val", get_rdata(i), 32'hDE22BE44);
            held_req(i, 6'd4);
        end
        reset_mid(0);

        for (int n = 0; n < 80; n++) begin
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            a = {24'd0, 6'($urandom), 2'b00};
            if (r == 7) a = a + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'($urandom_range(64, 300)) << 2;
            else if (r == 9) a = $urandom;
            access(s, 1'($urandom), a, $urandom, 4'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
